state_reg_bank: RTL and testbench

//  Parametrised permutation-state register for the ASCON datapath; successor to the plain enabled dff.

---
 rtl/state_reg_bank.sv | 108 ++++++++++
 tb/tb_state_reg_bank.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/state_reg_bank.sv
// Purpose : NB_LANES x LANE_W permutation-state register with masked load, in-place XOR absorb
//           and a lane-serial load FSM for narrow front-ends.
// Latency : every update is visible on q_o right after the clock edge that applies it.
// Backpr. : ser_ready_o follows enable_i while a serial load is in progress; enable_i=0 stalls all ops.
//
// Ports
//   clock_i, resetb_i            clock (rising edge) and async active-low reset
//   enable_i, clear_i            global advance enable; synchronous clear (works even with enable_i=0)
//   mode_i, lane_mask_i, d_i     parallel op (00 hold, 01 load, 10 xor, 11 hold) on masked lanes
//   ser_start_i/valid_i/lane_i   serial load start, lane valid, lane data
//   ser_ready_o, busy_o, done_o  serial handshake, load in progress, one-cycle completion pulse
//   q_o                          registered state, lane 0 = x0
module state_reg_bank #(
    parameter int                NB_LANES  = 5,
    parameter int                LANE_W    = 64,
    parameter logic [LANE_W-1:0] RESET_VAL = '0
) (
    input  logic                               clock_i,
    input  logic                               resetb_i,
    input  logic                               enable_i,
    input  logic                               clear_i,
    input  logic [1:0]                         mode_i,
    input  logic [NB_LANES-1:0]                lane_mask_i,
    input  logic [NB_LANES-1:0][LANE_W-1:0]    d_i,
    input  logic                               ser_start_i,
    input  logic                               ser_valid_i,
    input  logic [LANE_W-1:0]                  ser_lane_i,
    output logic                               ser_ready_o,
    output logic                               busy_o,
    output logic                               done_o,
    output logic [NB_LANES-1:0][LANE_W-1:0]    q_o
);

    localparam int              CNT_W    = (NB_LANES > 1) ? $clog2(NB_LANES) : 1;
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(NB_LANES - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SLOAD = 1'b1
    } state_t;

    state_t                            r_state;
    logic [CNT_W-1:0]                  r_cnt;
    logic                              r_done;
    logic [NB_LANES-1:0][LANE_W-1:0]   r_q;

    logic w_busy;
    logic w_ser_acc;

    assign w_busy    = (r_state == ST_SLOAD);
    // A serial lane is taken only when the bank is allowed to advance this cycle.
    assign w_ser_acc = w_busy & enable_i & ser_valid_i;

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_q     <= {NB_LANES{RESET_VAL}};
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else if (clear_i) begin
            r_q     <= {NB_LANES{RESET_VAL}};
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_SLOAD: begin
                    // mode_i and ser_start_i are deliberately ignored while loading.
                    if (w_ser_acc) begin
                        r_q[r_cnt] <= ser_lane_i;
                        if (r_cnt == LAST_LANE) begin
                            r_state <= ST_IDLE;
                            r_cnt   <= '0;
                            r_done  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    if (enable_i) begin
                        // The parallel op still lands on the same edge that starts a serial load.
                        for (int k = 0; k < NB_LANES; k++) begin
                            if (lane_mask_i[k]) begin
                                case (mode_i)
                                    2'b01:   r_q[k] <= d_i[k];
                                    2'b10:   r_q[k] <= r_q[k] ^ d_i[k];
                                    default: r_q[k] <= r_q[k];
                                endcase
                            end
                        end
                        if (ser_start_i) begin
                            r_state <= ST_SLOAD;
                            r_cnt   <= '0;
                        end
                    end
                end
            endcase
        end
    end

    assign q_o         = r_q;
    assign busy_o      = w_busy;
    assign ser_ready_o = w_busy & enable_i;
    assign done_o      = r_done;

endmodule

// File: tb/tb_state_reg_bank.sv
// Purpose : directed self-checking bench for state_reg_bank (5 x 64-bit lanes).
// Latency : inputs change 1 ns after a rising edge, outputs are sampled 1 ns after the next one.
// Backpr. : serial stalls are produced by dropping enable_i between accepted lanes.
module tb_state_reg_bank;

    localparam int NL = 5;
    localparam int LW = 64;

    logic                   clk;
    logic                   rst_n;
    logic                   enable;
    logic                   clear;
    logic [1:0]             mode;
    logic [NL-1:0]          mask;
    logic [NL-1:0][LW-1:0]  d;
    logic                   ser_start;
    logic                   ser_valid;
    logic [LW-1:0]          ser_lane;
    logic                   ser_ready;
    logic                   busy;
    logic                   done;
    logic [NL-1:0][LW-1:0]  q;

    logic [NL-1:0][LW-1:0]  exp_q;
    int n_tests = 0;
    int n_fail  = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    bit mon_on = 1'b0;

    state_reg_bank #(.NB_LANES(NL), .LANE_W(LW), .RESET_VAL('0)) dut (
        .clock_i     (clk),
        .resetb_i    (rst_n),
        .enable_i    (enable),
        .clear_i     (clear),
        .mode_i      (mode),
        .lane_mask_i (mask),
        .d_i         (d),
        .ser_start_i (ser_start),
        .ser_valid_i (ser_valid),
        .ser_lane_i  (ser_lane),
        .ser_ready_o (ser_ready),
        .busy_o      (busy),
        .done_o      (done),
        .q_o         (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        if (mon_on) begin
            busy_cnt += int'(busy);
            done_cnt += int'(done);
        end
    endtask

    task automatic chk_q(input string tag, input logic [NL*LW-1:0] obs, input logic [NL*LW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_n(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; clear = 1'b0; mode = 2'b00; mask = '0; d = '0;
        ser_start = 1'b0; ser_valid = 1'b0; ser_lane = '0;

        // 1. reset
        tick(); tick();
        #3 rst_n = 1'b1;
        #1;
        chk_q("reset_q", q, '0);
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_ready", ser_ready, 1'b0);
        chk1("reset_done", done, 1'b0);

        // 2. masked load: lanes 0,2,4 take 1,3,5
        tick();
        enable = 1'b1; mode = 2'b01; mask = 5'b10101;
        for (int k = 0; k < NL; k++) d[k] = 64'(k + 1);
        tick();
        exp_q = '0;
        exp_q[0] = 64'd1; exp_q[2] = 64'd3; exp_q[4] = 64'd5;
        chk_q("load_masked", q, exp_q);

        // 3. xor absorb on lanes 0,1
        mode = 2'b10; mask = 5'b00011;
        for (int k = 0; k < NL; k++) d[k] = 64'hFF;
        tick();
        exp_q[0] = 64'hFE; exp_q[1] = 64'hFF;
        chk_q("xor_masked", q, exp_q);

        // reserved mode and disabled load both hold
        mode = 2'b11; mask = 5'b11111;
        for (int k = 0; k < NL; k++) d[k] = 64'hDEAD_BEEF_0000_0000 | 64'(k);
        tick();
        chk_q("mode11_hold", q, exp_q);
        mode = 2'b01; enable = 1'b0;
        tick();
        chk_q("enable0_hold", q, exp_q);
        chk1("idle_ready", ser_ready, 1'b0);

        // 4. serial load with a 2-cycle stall after A1; mode_i=01 must be ignored while busy
        enable = 1'b1; mode = 2'b00; ser_start = 1'b1; mon_on = 1'b1;
        tick();
        chk1("sload_busy", busy, 1'b1);
        chk1("sload_ready", ser_ready, 1'b1);
        ser_start = 1'b0; ser_valid = 1'b1; ser_lane = 64'hA0;
        mode = 2'b01; mask = 5'b11111;
        for (int k = 0; k < NL; k++) d[k] = '1;
        tick();
        ser_lane = 64'hA1;
        tick();
        enable = 1'b0; ser_lane = 64'hA2;
        #1;
        chk1("stall_ready", ser_ready, 1'b0);
        tick(); tick();
        enable = 1'b1;
        tick();
        ser_lane = 64'hA3; ser_start = 1'b1;
        tick();
        ser_start = 1'b0; ser_lane = 64'hA4;
        tick();
        chk1("ser_done_pulse", done, 1'b1);
        chk1("ser_busy_off", busy, 1'b0);
        ser_valid = 1'b0; mode = 2'b00;
        tick();
        mon_on = 1'b0;
        chk1("done_one_cycle", done, 1'b0);
        for (int k = 0; k < NL; k++) exp_q[k] = 64'hA0 + 64'(k);
        chk_q("ser_lanes", q, exp_q);
        chk_n("busy_cycles", busy_cnt, 7);
        chk_n("done_count", done_cnt, 1);

        // 5. clear after two serial lanes, then restart at lane 0
        ser_start = 1'b1;
        tick();
        ser_start = 1'b0; ser_valid = 1'b1; ser_lane = 64'hB0;
        tick();
        ser_lane = 64'hB1;
        tick();
        ser_valid = 1'b0; clear = 1'b1; enable = 1'b0;
        tick();
        chk_q("clear_q", q, '0);
        chk1("clear_busy", busy, 1'b0);
        clear = 1'b0; enable = 1'b1; ser_start = 1'b1;
        tick();
        ser_start = 1'b0; ser_valid = 1'b1; ser_lane = 64'hC0;
        tick();
        exp_q = '0; exp_q[0] = 64'hC0;
        chk_q("restart_lane0", q, exp_q);
        ser_lane = 64'hC1;
        tick();

        // 6. mode ignored while busy, then async reset between edges
        ser_valid = 1'b0; mode = 2'b01; mask = 5'b11111;
        for (int k = 0; k < NL; k++) d[k] = '1;
        tick();
        exp_q[1] = 64'hC1;
        chk_q("busy_mode_ignored", q, exp_q);
        chk1("busy_still", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_q("async_reset_q", q, '0);
        chk1("async_reset_busy", busy, 1'b0);
        chk1("async_reset_ready", ser_ready, 1'b0);
        #2 rst_n = 1'b1;
        mode = 2'b00;
        tick();
        chk_q("post_reset_q", q, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
